// File: rtl/power_sbox_array.sv
// power_sbox_array
//   Generates repeatable AES S-box activity for side-channel
//   characterisation. Each trace does the following:
//     1. It waits a quiet period.
//     2. It shifts LANES LFSR bytes into a plaintext register.
//     3. It runs ROUNDS chained S-box passes over all byte lanes.
//   trigger marks the S-box passes.
//
// Ports
//   ICE_CLK    clock
//   resetn     synchronous, active-low reset
//   start      single-trace request (pulse), ignored while busy
//   free_run   back-to-back traces while high (level)
//   dec        1 = inverse S-box, 0 = forward; latched at each trace launch
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of each trace
//   trigger    high during the S-box passes
//   data_out   S-box state register (LANES*8 bits)
//   dummy_o    bit 0 of the S-box state
//   fsm_state  current FSM state, for observation
//
// Request semantics:
//   - A launch happens on any edge in IDLE where start or free_run is high.
//   - Both inputs high on the same edge give one launch.
//   - Nothing is queued.
//   - From DONE, free_run high relaunches immediately. Otherwise the block
//     returns to IDLE.
//
// Build option: define POWER_SBOX_MASK_EN to XOR every S-box input byte
// with MASK_BYTE. Without it, inputs are unmasked. Timing is identical
// in both builds.
module power_sbox_array #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ROUNDS      = 4,
  parameter int unsigned IDLE_CYCLES = 11,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1ACE1,
  parameter logic [7:0]  MASK_BYTE   = 8'hDE
) (
  input  logic                 ICE_CLK,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 free_run,
  input  logic                 dec,
  output logic                 busy,
  output logic                 done,
  output logic                 trigger,
  output logic [LANES*8-1:0]   data_out,
  output logic                 dummy_o,
  output logic [2:0]           fsm_state
);

  localparam int unsigned W = LANES * 8;

  localparam logic [7:0] WAIT_LAST  = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] ADV_LAST   = 8'(LANES - 1);
  localparam logic [7:0] ROUND_LAST = 8'(ROUNDS - 1);

`ifdef POWER_SBOX_MASK_EN
  localparam logic [7:0] IN_MASK = MASK_BYTE;
`else
  // Masking disabled: this folds to zero and the XOR disappears.
  localparam logic [7:0] IN_MASK = MASK_BYTE & 8'h00;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ADVANCE = 3'd2,
    S_ROUND   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic [31:0]   lfsr;
  logic [W-1:0]  pt, st;
  logic          dec_q;
  logic          lat_en, adv_en, rnd_en;
  logic [W-1:0]  pt_shift, sbox_in, sbox_out;

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128.
  // Zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // The forward S-box is the inverse followed by the affine map.
  // The inverse S-box is the inverse affine map followed by the inverse.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x, input logic inv);
    logic [7:0] b;
    logic [7:0] y;
    if (inv) begin
      y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      b = gf_inv(y);
    end else begin
      y = gf_inv(x);
      b = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    end
    return b;
  endfunction

  function automatic logic [31:0] lfsr_adv8(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    end
    return r;
  endfunction

  // Byte shift written so that LANES=1 needs no zero-width slice.
  always_comb begin
    pt_shift      = pt << 8;
    pt_shift[7:0] = lfsr[7:0];
  end

  // The first pass reads the plaintext. Later passes chain on the state.
  // The counter is zero only on the first ROUND cycle.
  always_comb begin
    sbox_out = '0;
    sbox_in  = (cnt == 8'd0) ? pt : st;
    for (int i = 0; i < int'(LANES); i++) begin
      sbox_out[8*i +: 8] = sbox_byte(sbox_in[8*i +: 8] ^ IN_MASK, dec_q);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat_en   = 1'b0;
    adv_en   = 1'b0;
    rnd_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    trigger  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start || free_run) begin
          lat_en   = 1'b1;
          cnt_nx   = 8'd0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = S_ADVANCE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_ADVANCE: begin
        adv_en = 1'b1;
        if (cnt == ADV_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = S_ROUND;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_ROUND: begin
        rnd_en  = 1'b1;
        trigger = 1'b1;
        if (cnt == ROUND_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (free_run) begin
          lat_en   = 1'b1;
          cnt_nx   = 8'd0;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      lfsr  <= LFSR_SEED;
      pt    <= '0;
      st    <= '0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (lat_en) dec_q <= dec;
      if (adv_en) begin
        lfsr <= lfsr_adv8(lfsr);
        pt   <= pt_shift;
      end
      if (rnd_en) st <= sbox_out;
    end
  end

  assign data_out  = st;
  assign dummy_o   = st[0];
  assign fsm_state = state;

endmodule

// File: tb/tb_power_sbox_array.sv
// tb_power_sbox_array
//   Directed-then-random bench for power_sbox_array. There are three
//   instances:
//     d   default parameters
//     z1  LFSR seed 0, one round, MASK_BYTE 63
//     z2  LFSR seed 0, two rounds, MASK_BYTE 63
//   The reference model uses the published AES S-box table. The inverse
//   table is derived from it, and LFSR stepping uses plain arithmetic.
module tb_power_sbox_array;

  localparam logic [31:0] SEED_D = 32'hACE1ACE1;
  localparam logic [7:0]  MASK_D = 8'hDE;
  localparam logic [7:0]  MASK_Z = 8'h63;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic start_d, free_d, dec_d;
  logic start_z, dec_z;
  logic zero_in;

  logic        busy_d, done_d, trig_d, dummy_d;
  logic [31:0] data_d;
  logic [2:0]  fsm_d;
  logic        busy_z1, done_z1, trig_z1, dummy_z1;
  logic [31:0] data_z1;
  logic [2:0]  fsm_z1;
  logic        busy_z2, done_z2, trig_z2, dummy_z2;
  logic [31:0] data_z2;
  logic [2:0]  fsm_z2;

  power_sbox_array u_d (
    .ICE_CLK(clk), .resetn(resetn), .start(start_d), .free_run(free_d), .dec(dec_d),
    .busy(busy_d), .done(done_d), .trigger(trig_d), .data_out(data_d),
    .dummy_o(dummy_d), .fsm_state(fsm_d)
  );

  power_sbox_array #(.LFSR_SEED(32'h0), .ROUNDS(1), .MASK_BYTE(MASK_Z)) u_z1 (
    .ICE_CLK(clk), .resetn(resetn), .start(start_z), .free_run(zero_in), .dec(dec_z),
    .busy(busy_z1), .done(done_z1), .trigger(trig_z1), .data_out(data_z1),
    .dummy_o(dummy_z1), .fsm_state(fsm_z1)
  );

  power_sbox_array #(.LFSR_SEED(32'h0), .ROUNDS(2), .MASK_BYTE(MASK_Z)) u_z2 (
    .ICE_CLK(clk), .resetn(resetn), .start(start_z), .free_run(zero_in), .dec(dec_z),
    .busy(busy_z2), .done(done_z2), .trigger(trig_z2), .data_out(data_z2),
    .dummy_o(dummy_z2), .fsm_state(fsm_z2)
  );

  // scoreboard / reference model
  logic [7:0]  sbox_fwd [256];
  logic [7:0]  sbox_inv [256];
  logic [31:0] m_lfsr;
  int          n_vec = 0;
  int          n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One whole trace at the behavioural level:
  //   - LANES(4) bytes taken from the LFSR, each followed by 8 steps;
  //   - then `rounds` S-box passes over all four bytes.
  task automatic model_run(input logic [31:0] l_in, input int rounds, input logic d,
                           input logic [7:0] mask, output logic [31:0] l_out,
                           output logic [31:0] res);
    logic [31:0] l;
    logic [31:0] s;
    logic [7:0]  mk;
    logic [7:0]  b;
    l = l_in;
    s = 32'h0;
`ifdef POWER_SBOX_MASK_EN
    mk = mask;
`else
    mk = 8'h00 & mask;
`endif
    for (int k = 0; k < 4; k++) begin
      s = (s << 8) | {24'h0, l[7:0]};
      for (int j = 0; j < 8; j++) l = (l << 1) | {31'h0, ^(l & 32'h80200003)};
    end
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 4; k++) begin
        b = s[8*k +: 8] ^ mk;
        s[8*k +: 8] = d ? sbox_inv[b] : sbox_fwd[b];
      end
    end
    l_out = l;
    res   = s;
  endtask

  // driver: waits (bounded) for done on the default instance and releases
  // start after the launch edge.
  task automatic wait_done_d(input int budget, output int n, output int tg,
                             output logic [31:0] q, output logic dm);
    n  = 0;
    tg = 0;
    q  = 32'h0;
    dm = 1'b0;
    for (int i = 1; i <= budget && n == 0; i++) begin
      @(negedge clk);
      if (i == 1) start_d = 1'b0;
      if (trig_d) tg++;
      if (done_d) begin
        n  = i;
        q  = data_d;
        dm = dummy_d;
      end
    end
  endtask

  task automatic run_z(input logic d);
    int          n1, n2, t1, t2;
    logic [31:0] q1, q2, e1, e2, lo;
    logic        dm1, dm2;
    n1 = 0; n2 = 0; t1 = 0; t2 = 0;
    q1 = 32'h0; q2 = 32'h0; dm1 = 1'b0; dm2 = 1'b0;
    model_run(32'h0, 1, d, MASK_Z, lo, e1);
    model_run(32'h0, 2, d, MASK_Z, lo, e2);
    @(negedge clk);
    start_z = 1'b1;
    dec_z   = d;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start_z = 1'b0;
      if (trig_z1) t1++;
      if (trig_z2) t2++;
      if (done_z1 && n1 == 0) begin n1 = i; q1 = data_z1; dm1 = dummy_z1; end
      if (done_z2 && n2 == 0) begin n2 = i; q2 = data_z2; dm2 = dummy_z2; end
    end
    check("z1_done_latency", n1, 17);
    check("z2_done_latency", n2, 18);
    check("z1_data", q1, e1);
    check("z2_data", q2, e2);
    check("z1_dummy", {31'h0, dm1}, {31'h0, e1[0]});
    check("z2_dummy", {31'h0, dm2}, {31'h0, e2[0]});
    check("z1_trigger_cycles", t1, 1);
    check("z2_trigger_cycles", t2, 2);
    check("z_idle_after", {30'h0, busy_z1, busy_z2}, 32'h0);
  endtask

  initial begin
    int          n, tg, n0;
    logic [31:0] q, e, first_val;
    logic        dm, r, r2, found;

    for (int i = 0; i < 256; i++) sbox_fwd[i] = SBOX_HEX[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) sbox_inv[sbox_fwd[i]] = 8'(i);

    resetn  = 1'b0;
    start_d = 1'b0; free_d = 1'b0; dec_d = 1'b0;
    start_z = 1'b0; dec_z = 1'b0; zero_in = 1'b0;
    m_lfsr  = SEED_D;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", {29'h0, busy_d, busy_z1, busy_z2}, 32'h0);
    check("rst_done", {29'h0, done_d, done_z1, done_z2}, 32'h0);
    check("rst_trigger", {29'h0, trig_d, trig_z1, trig_z2}, 32'h0);
    check("rst_dummy", {29'h0, dummy_d, dummy_z1, dummy_z2}, 32'h0);
    check("rst_data_d", data_d, 32'h0);
    check("rst_data_z", data_z1 | data_z2, 32'h0);
    resetn = 1'b1;

    // zero-seed directed traces, forward then inverse
    run_z(1'b0);
    run_z(1'b1);

    // free-run: three traces, dec flipped mid trace 2, free_run dropped in trace 3
    r = 1'($urandom_range(0, 1));
    @(negedge clk);
    free_d = 1'b1;
    dec_d  = r;
    wait_done_d(40, n, tg, q, dm);
    model_run(m_lfsr, 4, r, MASK_D, m_lfsr, e);
    first_val = e;
    check("fr1_period", n, 20);
    check("fr1_trigger", tg, 4);
    check("fr1_data", q, e);
    check("fr1_dummy", {31'h0, dm}, {31'h0, e[0]});

    repeat (3) @(negedge clk);
    dec_d = ~r;
    wait_done_d(40, n, tg, q, dm);
    model_run(m_lfsr, 4, r, MASK_D, m_lfsr, e);
    check("fr2_period", n + 3, 20);
    check("fr2_trigger", tg, 4);
    check("fr2_data", q, e);

    repeat (5) @(negedge clk);
    free_d = 1'b0;
    wait_done_d(40, n, tg, q, dm);
    model_run(m_lfsr, 4, ~r, MASK_D, m_lfsr, e);
    check("fr3_period", n + 5, 20);
    check("fr3_trigger", tg, 4);
    check("fr3_data", q, e);
    @(negedge clk);
    check("fr_stop_idle", {31'h0, busy_d}, 32'h0);
    repeat (4) @(negedge clk);
    check("fr_stays_idle", {31'h0, busy_d}, 32'h0);

    // start pulsed during ROUND is ignored and not queued
    r2 = 1'($urandom_range(0, 1));
    @(negedge clk);
    start_d = 1'b1;
    dec_d   = r2;
    n0 = 0;
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (i == 1) start_d = 1'b0;
      if (trig_d) begin found = 1'b1; n0 = i; end
    end
    check("first_trigger_cycle", n0, 16);
    start_d = 1'b1;
    wait_done_d(40, n, tg, q, dm);
    model_run(m_lfsr, 4, r2, MASK_D, m_lfsr, e);
    check("busy_start_done_at", n, 4);
    check("busy_start_trigger", tg, 3);
    check("busy_start_data", q, e);
    @(negedge clk);
    check("no_queue_idle", {31'h0, busy_d}, 32'h0);
    repeat (3) @(negedge clk);
    check("no_queue_still_idle", {31'h0, busy_d}, 32'h0);

    // reset in the middle of ADVANCE
    @(negedge clk);
    start_d = 1'b1;
    dec_d   = ~r;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) start_d = 1'b0;
    end
    check("pre_reset_busy", {31'h0, busy_d}, 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_lfsr = SEED_D;
    check("mid_rst_busy", {31'h0, busy_d}, 32'h0);
    check("mid_rst_data", data_d, 32'h0);
    check("mid_rst_flags", {29'h0, done_d, trig_d, dummy_d}, 32'h0);

    // next trace reproduces the first trace from the seed
    @(negedge clk);
    start_d = 1'b1;
    dec_d   = r;
    wait_done_d(40, n, tg, q, dm);
    model_run(m_lfsr, 4, r, MASK_D, m_lfsr, e);
    check("replay_latency", n, 20);
    check("replay_first_value", q, first_val);

    // random single traces, some with start and free_run raised together
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      r2 = 1'($urandom_range(0, 1));
      start_d = 1'b1;
      free_d  = 1'($urandom_range(0, 1));
      dec_d   = r2;
      @(negedge clk);
      start_d = 1'b0;
      free_d  = 1'b0;
      dec_d   = 1'($urandom_range(0, 1));
      wait_done_d(40, n, tg, q, dm);
      model_run(m_lfsr, 4, r2, MASK_D, m_lfsr, e);
      check("rnd_latency", n + 1, 20);
      check("rnd_trigger", tg, 4);
      check("rnd_data", q, e);
      @(negedge clk);
      check("rnd_single_launch", {31'h0, busy_d}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/power_sbox_array.md
POWER_SBOX_ARRAY -- requirements
Module: power_sbox_array

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of parallel 8-bit S-box lanes (legal range 1..16).
REQ-002 The block SHALL have parameter ROUNDS, default 4, meaning the number of chained S-box passes per trace (legal range 1..15).
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 11, meaning the quiet cycles before each trace (legal range 1..255).
REQ-004 The block SHALL have parameter LFSR_SEED, default 32'hACE1ACE1, meaning the LFSR reset value.
REQ-005 The block SHALL have parameter MASK_BYTE, default 8'hDE, meaning the per-lane XOR constant (used only under REQ-026).
REQ-006 The block SHALL have port ICE_CLK, input, 1 bit, meaning the clock.
REQ-007 The block SHALL have port resetn, input, 1 bit, meaning reset: synchronous, active-low, clock ICE_CLK.
REQ-008 The block SHALL have port start, input, 1 bit, meaning a single-trace request (pulse).
REQ-009 The block SHALL have port free_run, input, 1 bit, meaning back-to-back traces while high (level).
REQ-010 The block SHALL have port dec, input, 1 bit, meaning 1 = inverse S-box and 0 = forward S-box, sampled on trace launch.
REQ-011 The block SHALL have outputs busy (1 bit), done (1 bit), trigger (1 bit), data_out (LANES*8 bits) and dummy_o (1 bit).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, ADVANCE, ROUND and DONE.
REQ-013 In IDLE, a clock edge with start=1 or free_run=1 SHALL latch dec, clear the cycle counter and enter WAIT.
REQ-014 WAIT SHALL last exactly IDLE_CYCLES cycles with no register activity other than the counter, then enter ADVANCE.
REQ-015 ADVANCE SHALL last LANES cycles; each cycle the LFSR SHALL advance 8 steps, and pt <= {pt[LANES*8-9:0], lfsr[7:0]} (pre-advance value).
REQ-016 The LFSR SHALL be 32 bits; one step SHALL be lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
REQ-017 An all-zero LFSR SHALL remain zero; there SHALL be no lock-up escape.
REQ-018 ROUND SHALL last ROUNDS cycles: the first cycle SHALL load st <= S(pt), each later cycle SHALL load st <= S(st), where S is applied per byte lane and is the forward or inverse S-box per the latched dec.
REQ-019 The S-box SHALL be combinational, with no added pipeline stage.
REQ-020 DONE SHALL last 1 cycle with done=1; the next state SHALL be WAIT if free_run=1, else IDLE.
REQ-021 The timing SHALL be: start sampled at edge t gives done=1 during cycle t+IDLE_CYCLES+LANES+ROUNDS+1.
REQ-022 Output behaviour: busy=1 in every state except IDLE; trigger=1 only in ROUND; data_out=st continuously; dummy_o=st[0].
REQ-023 start while busy=1 SHALL be ignored, with no queuing; deassertion of free_run mid-trace SHALL let the trace complete, then go to IDLE.
REQ-024 start and free_run asserted together SHALL be treated as one launch.

Reset
REQ-025 resetn=0 at any edge, including mid-trace, SHALL force state=IDLE, lfsr=LFSR_SEED, pt=0, st=0, counter=0, latched dec=0, with busy=done=trigger=dummy_o=0 and data_out=0 from the next cycle.

Configuration
REQ-026 With macro POWER_SBOX_MASK_EN defined, every S-box input byte SHALL be XORed with MASK_BYTE (S(x^MASK_BYTE)); without the macro, inputs SHALL be unmasked and MASK_BYTE SHALL be unused, with all timing identical in both builds.

Verification
REQ-027 Scenario: LFSR_SEED=0, LANES=4, ROUNDS=1, dec=0, no mask, start pulse -> data_out=32'h63636363 at done, with done exactly 17 cycles after the start edge (IDLE_CYCLES=11).
REQ-028 Scenario: LFSR_SEED=0, ROUNDS=2, dec=0 -> data_out bytes all 8'hFB; with dec=1 and ROUNDS=1 -> bytes all 8'h52.
REQ-029 Scenario: POWER_SBOX_MASK_EN defined, MASK_BYTE=8'h63, LFSR_SEED=0, ROUNDS=1, dec=0 -> bytes all 8'hFB.
REQ-030 Scenario: default parameters, free_run held high for 3 traces -> done pulses every 20 cycles; trigger high for exactly 4 cycles per trace; data_out matches the software LFSR + S-box model.
REQ-031 Scenario: start pulsed during ROUND, then resetn=0 for 1 cycle mid-ADVANCE -> the extra start is ignored; after reset busy=0, data_out=0, and the next trace reproduces the first-trace value from LFSR_SEED.
